// File: rtl/axi_stream_f_if.sv
// Write-side bundle of the byte-packing adapter: keep-qualified beat from the
// DSP source plus the FIFO write port (data_word/w_en) and its full flag.
interface axi_stream_f_if #(
  parameter int t_data_w = 4
) ();
  logic [t_data_w-1:0]   info_bits;
  logic [8*t_data_w-1:0] dsp_in_data;
  logic                  full;
  logic [8*t_data_w-1:0] data_word;
  logic                  w_en;

  modport master (
    output info_bits,
    output dsp_in_data,
    output full,
    input  data_word,
    input  w_en
  );

  modport slave (
    input  info_bits,
    input  dsp_in_data,
    input  full,
    output data_word,
    output w_en
  );
endinterface

// File: rtl/axi_stream_f.sv
// Compacts keep-qualified bytes of each beat into a shift-compacting byte
// accumulator and writes whole words to a downstream FIFO while it is not full.
module axi_stream_f #(
  parameter int t_data_w = 4
) (
  input logic           aclk,
  input logic           aresetn,
  axi_stream_f_if.slave bus
);
  localparam int DATA_BITS = 8 * t_data_w;
  localparam int CAP       = 4 * t_data_w;
  localparam int CNT_W     = $clog2(CAP + 1);
  localparam int SUM_W     = CNT_W + 1;
  localparam int POP_W     = $clog2(t_data_w + 1);
  localparam int PTR_W     = $clog2(CAP);

  // Byte 0 of acc_r is always the oldest buffered byte; slots at or above cnt_r stay zero.
  logic [8*CAP-1:0]     acc_r;
  logic [8*CAP-1:0]     acc_nxt_s;
  logic [8*CAP-1:0]     base_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [CNT_W-1:0]     cnt_left_s;
  logic [SUM_W-1:0]     sum_s;
  logic [SUM_W-1:0]     wr_s;
  logic [POP_W-1:0]     n_s;
  logic                 pop_s;
  logic                 fits_s;
  logic [7:0]           slot_s [CAP];
  logic [DATA_BITS-1:0] word_r;
  logic                 w_en_r;

  function automatic logic [POP_W-1:0] popcount(input logic [t_data_w-1:0] mask);
    logic [POP_W-1:0] n;
    n = {POP_W{1'b0}};
    for (int i = 0; i < t_data_w; i++) begin
      n = n + POP_W'(mask[i]);
    end
    return n;
  endfunction

  // Pop decision: a whole word is buffered and the FIFO can accept it.
  always_comb begin
    if ((cnt_r >= CNT_W'(t_data_w)) && (bus.full == 1'b0)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Remove the popped word, then append the beat only if every kept byte fits.
  always_comb begin
    acc_nxt_s = {(8*CAP){1'b0}};
    if (pop_s) begin
      base_s     = acc_r >> DATA_BITS;
      cnt_left_s = cnt_r - CNT_W'(t_data_w);
    end else begin
      base_s     = acc_r;
      cnt_left_s = cnt_r;
    end

    n_s   = popcount(bus.info_bits);
    sum_s = SUM_W'(cnt_left_s) + SUM_W'(n_s);
    if ((n_s != {POP_W{1'b0}}) && (sum_s <= SUM_W'(CAP))) begin
      fits_s = 1'b1;
    end else begin
      fits_s = 1'b0;
    end

    for (int i = 0; i < CAP; i++) begin
      slot_s[i] = base_s[8*i +: 8];
    end

    wr_s = SUM_W'(cnt_left_s);
    for (int j = 0; j < t_data_w; j++) begin
      if (fits_s && bus.info_bits[j]) begin
        slot_s[wr_s[PTR_W-1:0]] = bus.dsp_in_data[8*j +: 8];
        wr_s                    = wr_s + SUM_W'(1);
      end else begin
        wr_s = wr_s;
      end
    end

    for (int i = 0; i < CAP; i++) begin
      acc_nxt_s[8*i +: 8] = slot_s[i];
    end

    if (fits_s) begin
      cnt_nxt_s = sum_s[CNT_W-1:0];
    end else begin
      cnt_nxt_s = cnt_left_s;
    end
  end

  // State and registered FIFO write port; aresetn is active-high here.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      acc_r  <= {(8*CAP){1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      word_r <= {DATA_BITS{1'b0}};
      w_en_r <= 1'b0;
    end else begin
      acc_r  <= acc_nxt_s;
      cnt_r  <= cnt_nxt_s;
      w_en_r <= pop_s;
      if (pop_s) begin
        word_r <= acc_r[DATA_BITS-1:0];
      end else begin
        word_r <= word_r;
      end
    end
  end

  assign bus.data_word = word_r;
  assign bus.w_en      = w_en_r;
endmodule

// File: tb/tb_axi_stream_f.sv
// Self-checking bench for axi_stream_f: directed scenarios plus a random soak
// scored against a byte-queue reference model.
module tb_axi_stream_f;
  localparam int T   = 4;
  localparam int CAP = 4 * T;

  logic aclk = 1'b0;
  logic aresetn;
  axi_stream_f_if #(.t_data_w(T)) bus ();

  axi_stream_f #(.t_data_w(T)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  ref_q [$];
  logic        exp_wen;
  logic [31:0] exp_word;

  // Drive one cycle, advance the reference model on the pre-edge inputs, sample #1 after the edge.
  task automatic tick(input logic rst, input logic [T-1:0] keep, input logic [8*T-1:0] data,
                      input logic f);
    int n;
    aresetn         = rst;
    bus.info_bits   = keep;
    bus.dsp_in_data = data;
    bus.full        = f;
    if (rst) begin
      ref_q.delete();
      exp_wen  = 1'b0;
      exp_word = 32'h0000_0000;
    end else begin
      if (ref_q.size() >= T && !f) begin
        for (int b = 0; b < T; b++) exp_word[8*b +: 8] = ref_q.pop_front();
        exp_wen = 1'b1;
      end else begin
        exp_wen = 1'b0;
      end
      n = $countones(keep);
      if (n > 0 && ref_q.size() + n <= CAP) begin
        for (int j = 0; j < T; j++) if (keep[j]) ref_q.push_back(data[8*j +: 8]);
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] want;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
      n_checks++;
      if (bus.w_en !== 1'b0 || bus.data_word !== 32'h0000_0000)
        $display("FAIL reset_state: w_en=%b data_word=%h, expected w_en=0 data_word=00000000",
                 bus.w_en, bus.data_word);
      else n_pass++;
    end
    want = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      want[8*i +: 8] = d[7:0];
      tick(1'b0, 4'b0001, d, 1'b0);
      n_checks++;
      if (bus.w_en !== 1'b0)
        $display("FAIL reset_no_early_wen: w_en=%b at byte %0d, expected 0", bus.w_en, i);
      else n_pass++;
    end
    tick(1'b0, 4'b0000, $urandom, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b1 || bus.data_word !== want)
      $display("FAIL reset_first_word: w_en=%b data_word=%h, expected w_en=1 data_word=%h",
               bus.w_en, bus.data_word, want);
    else n_pass++;
  endtask

  task automatic test_full_beat();
    tick(1'b1, 4'b0000, 32'h0, 1'b0);
    tick(1'b0, 4'b1111, 32'hAABB_CCDD, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b0)
      $display("FAIL full_beat_latency: w_en=%b at beat edge, expected 0", bus.w_en);
    else n_pass++;
    tick(1'b0, 4'b0000, 32'h0, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b1 || bus.data_word !== 32'hAABB_CCDD)
      $display("FAIL full_beat_word: w_en=%b data_word=%h, expected w_en=1 data_word=aabbccdd",
               bus.w_en, bus.data_word);
    else n_pass++;
    tick(1'b0, 4'b0000, 32'h0, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b0 || bus.data_word !== 32'hAABB_CCDD)
      $display("FAIL full_beat_hold: w_en=%b data_word=%h, expected w_en=0 data_word=aabbccdd",
               bus.w_en, bus.data_word);
    else n_pass++;
  endtask

  task automatic test_packing();
    tick(1'b1, 4'b0000, 32'h0, 1'b0);
    tick(1'b0, 4'b0011, 32'h1122_3344, 1'b0);
    tick(1'b0, 4'b0011, 32'h5566_7788, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b0)
      $display("FAIL packing_early: w_en=%b, expected 0", bus.w_en);
    else n_pass++;
    tick(1'b0, 4'b0101, 32'hDEAD_BEEF, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b1 || bus.data_word !== 32'h7788_3344)
      $display("FAIL packing_dense: w_en=%b data_word=%h, expected w_en=1 data_word=77883344",
               bus.w_en, bus.data_word);
    else n_pass++;
    tick(1'b0, 4'b0101, 32'hDEAD_BEEF, 1'b0);
    tick(1'b0, 4'b0000, 32'h0, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b1 || bus.data_word !== 32'hADEF_ADEF)
      $display("FAIL packing_sparse: w_en=%b data_word=%h, expected w_en=1 data_word=adefadef",
               bus.w_en, bus.data_word);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    tick(1'b1, 4'b0000, 32'h0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0, 4'b1111, 32'(i), 1'b1);
      n_checks++;
      if (bus.w_en !== 1'b0)
        $display("FAIL bp_stall: w_en=%b while full (beat %0d), expected 0", bus.w_en, i);
      else n_pass++;
    end
    for (int i = 1; i <= 4; i++) begin
      tick(1'b0, 4'b0000, 32'h0, 1'b0);
      n_checks++;
      if (bus.w_en !== 1'b1 || bus.data_word !== 32'(i))
        $display("FAIL bp_drain: w_en=%b data_word=%h, expected w_en=1 data_word=%h",
                 bus.w_en, bus.data_word, 32'(i));
      else n_pass++;
    end
    tick(1'b0, 4'b0000, 32'h0, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b0 || bus.data_word !== 32'h0000_0004)
      $display("FAIL bp_dropped: w_en=%b data_word=%h, expected w_en=0 data_word=00000004",
               bus.w_en, bus.data_word);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] prev;
    tick(1'b1, 4'b0000, 32'h0, 1'b0);
    prev = 32'h0;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      tick(1'b0, 4'b1111, d, 1'b0);
      if (i > 0) begin
        n_checks++;
        if (bus.w_en !== 1'b1 || bus.data_word !== prev)
          $display("FAIL stream_word: w_en=%b data_word=%h, expected w_en=1 data_word=%h",
                   bus.w_en, bus.data_word, prev);
        else n_pass++;
      end
      prev = d;
    end
    tick(1'b0, 4'b0000, 32'h0, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b1 || bus.data_word !== prev)
      $display("FAIL stream_last: w_en=%b data_word=%h, expected w_en=1 data_word=%h",
               bus.w_en, bus.data_word, prev);
    else n_pass++;
    tick(1'b0, 4'b0000, 32'h0, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b0)
      $display("FAIL stream_end: w_en=%b, expected 0", bus.w_en);
    else n_pass++;
  endtask

  task automatic test_zero_keep_and_mid_reset();
    tick(1'b1, 4'b0000, 32'h0, 1'b0);
    tick(1'b0, 4'b0001, 32'h0000_0011, 1'b0);
    tick(1'b0, 4'b0001, 32'h0000_0022, 1'b0);
    tick(1'b0, 4'b0001, 32'h0000_0033, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 4'b0000, $urandom, 1'b0);
    tick(1'b0, 4'b1000, 32'h4400_0000, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b0)
      $display("FAIL zero_keep_early: w_en=%b, expected 0", bus.w_en);
    else n_pass++;
    tick(1'b0, 4'b0011, 32'h0000_5566, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b1 || bus.data_word !== 32'h4433_2211)
      $display("FAIL zero_keep_word: w_en=%b data_word=%h, expected w_en=1 data_word=44332211",
               bus.w_en, bus.data_word);
    else n_pass++;
    tick(1'b1, 4'b1111, $urandom, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b0 || bus.data_word !== 32'h0000_0000)
      $display("FAIL mid_reset_state: w_en=%b data_word=%h, expected w_en=0 data_word=00000000",
               bus.w_en, bus.data_word);
    else n_pass++;
    tick(1'b0, 4'b0011, 32'h0000_A1A2, 1'b0);
    tick(1'b0, 4'b0011, 32'h0000_B1B2, 1'b0);
    tick(1'b0, 4'b0000, 32'h0, 1'b0);
    n_checks++;
    if (bus.w_en !== 1'b1 || bus.data_word !== 32'hB1B2_A1A2)
      $display("FAIL mid_reset_discard: w_en=%b data_word=%h, expected w_en=1 data_word=b1b2a1a2",
               bus.w_en, bus.data_word);
    else n_pass++;
  endtask

  task automatic test_random();
    logic f;
    logic r;
    tick(1'b1, 4'b0000, 32'h0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      f = ($urandom_range(0, 9) < 4);
      r = ($urandom_range(0, 149) == 0);
      tick(r, 4'($urandom_range(0, 15)), $urandom, f);
      if (f && !r) begin
        n_checks++;
        if (bus.w_en !== 1'b0)
          $display("FAIL soak_full_write: w_en=%b after full=1 at cycle %0d, expected 0",
                   bus.w_en, c);
        else n_pass++;
      end
      n_checks++;
      if (bus.w_en !== exp_wen || bus.data_word !== exp_word)
        $display("FAIL soak_word: cycle %0d w_en=%b data_word=%h, expected w_en=%b data_word=%h",
                 c, bus.w_en, bus.data_word, exp_wen, exp_word);
      else n_pass++;
    end
  endtask

  initial begin
    aresetn         = 1'b1;
    bus.info_bits   = 4'b0000;
    bus.dsp_in_data = 32'h0;
    bus.full        = 1'b0;
    exp_wen         = 1'b0;
    exp_word        = 32'h0;
    test_reset();
    test_full_beat();
    test_packing();
    test_backpressure();
    test_back_to_back();
    test_zero_keep_and_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_stream_f.md
Name: axi_stream_f

Overview:
- Byte-packing AXI-Stream-to-FIFO write adapter. Every cycle it takes one beat of `8*t_data_w` data bits with a per-byte keep mask (`info_bits`).
- It compacts the kept bytes into an internal byte accumulator and emits full words into a downstream FIFO through `data_word`/`w_en`, honouring the FIFO's `full` flag.
- It sits between a DSP datapath (no backpressure toward the source) and a synchronous FIFO write port.

Parameters:
- t_data_w, 4, beat width in bytes; data width DATA_BITS = 8*t_data_w; keep width = t_data_w.
- CAP (localparam), 4*t_data_w, accumulator capacity in bytes.

Ports:
- aclk  in  1  clock; all state updates on rising edge.
- aresetn  in  1  reset, synchronous, active-high (asserted when 1), despite the name.
- info_bits  in  t_data_w  byte keep mask; bit i qualifies byte i of dsp_in_data. All-zero means no beat this cycle.
- dsp_in_data  in  DATA_BITS  beat data; byte i = dsp_in_data[8i+7:8i].
- full  in  1  downstream FIFO full; no write may be issued while 1.
- data_word  out  DATA_BITS  packed word to FIFO; registered.
- w_en  out  1  FIFO write strobe, one-cycle pulse per emitted word; registered.

Behaviour:
- Reset (aresetn=1 at a rising edge):
  - data_word=0, w_en=0, accumulator byte count=0, accumulator contents=0.
  - Reset overrides any in-flight beat or pop.
  - Reset asserted mid-operation discards all buffered bytes.
- Accumulator: a FIFO-ordered byte store of CAP entries with count `cnt` (0..CAP).
- Per rising edge, out of reset, the two steps below are evaluated in order on pre-edge values.
- Pop:
  - If cnt >= t_data_w and full==0: data_word <= oldest t_data_w bytes (oldest byte in data_word[7:0], next in [15:8], ...), w_en <= 1, and those bytes are removed.
  - Otherwise w_en <= 0 and data_word holds its previous value.
- Append:
  - n = popcount(info_bits); cnt' = cnt - (pop ? t_data_w : 0).
  - If n>0 and cnt'+n <= CAP: kept bytes are appended after existing bytes in ascending byte-index order (lowest set keep bit first), skipping unkept bytes; cnt <= cnt'+n.
  - If cnt'+n > CAP: the whole beat is dropped (no partial append), cnt <= cnt'.
- Same-cycle pop and append are allowed; the popped word never contains bytes from the beat sampled at that same edge.
- Latency: a beat that completes a word at edge k produces w_en=1 after edge k+1, provided full==0 at edge k+1.
- Throughput: at most one word per cycle. With all keep bits set and full==0, sustains one word per cycle indefinitely with cnt steady at t_data_w.
- full==1 freezes popping only; appends continue until CAP is reached, after which beats are dropped.
- When full deasserts, buffered words drain one per cycle in order.
- No flag is raised on a drop.
- Partial words (cnt < t_data_w) remain buffered indefinitely; there is no flush or timeout.
- Arithmetic: count fields sized for 0..CAP; popcount width ceil(log2(t_data_w+1)). No wrap-around permitted; implement as a shift-compacting register or a circular buffer with modulo-CAP pointers.

Test Plan:
- Reset: hold aresetn=1 for 2 edges with random inputs -> data_word=0, w_en=0; after release, no w_en until a full word has accumulated.
- Full beat:
  - Stimulus: info_bits=1111, dsp_in_data=0xAABBCCDD for one cycle, full=0.
  - Response: one edge later w_en=1 with data_word=0xAABBCCDD for exactly one cycle; then w_en=0 and data_word holds 0xAABBCCDD.
- Packing:
  - Stimulus: beat 0011/0x11223344, then beat 0011/0x55667788.
  - Response: one edge after the second beat, w_en=1 with data_word=0x77883344.
  - Sparse keep: 0101/0xDEADBEEF twice -> data_word=0xADEFADEF.
- Backpressure:
  - Stimulus: with full=1, send five beats 1111 with 0x00000001..0x00000005.
  - Response: w_en stays 0; beat 5 is dropped (CAP reached).
  - Then set full=0: four consecutive w_en pulses with data_word 0x1,0x2,0x3,0x4; no fifth word.
- Simultaneous: cnt=4 with full=0 and a 1111 beat arriving at the same edge -> old word popped, new beat appended, cnt stays 4; continuous streaming yields one w_en per cycle.
- Zero keep and random: info_bits=0000 with any data -> no change to cnt. A random soak of info_bits, dsp_in_data and full must satisfy all of the following against a byte-queue scoreboard:
  - w_en never 1 in a cycle following a sampled full=1.
  - Emitted words match the reference byte queue.
